// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch (M:SS.T) with a 0.1 s prescaler, up/down counting
// and a lap-hold register that freezes the displayed value while the live count runs.
module bcd_stopwatch_counter #(
    parameter int TICK_WIDTH = 24,
    parameter int TICK_FINAL = 10_000_000
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            clr,
    input  logic            go,
    input  logic            up,
    input  logic            lap,
    output logic [3:0][3:0] parallel_out,
    output logic            wrap,
    output logic            lap_active
);

    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_FINAL - 1);

    logic [TICK_WIDTH-1:0] presc_r;
    logic [TICK_WIDTH-1:0] presc_nxt_s;
    logic [3:0][3:0]       live_r;
    logic [3:0][3:0]       live_nxt_s;
    logic [3:0][3:0]       lap_val_r;
    logic [3:0][3:0]       lap_val_nxt_s;
    logic [3:0][3:0]       out_r;
    logic [3:0][3:0]       out_nxt_s;
    logic                  wrap_r;
    logic                  wrap_nxt_s;
    logic                  lap_active_r;
    logic                  lap_active_nxt_s;
    logic                  lap_prev_r;
    logic                  tick_s;
    logic                  lap_edge_s;
    logic [16:0]           step_s;

    // One BCD step with ripple carry/borrow; returns {wrap, digits}.
    // Out-of-range digits are treated as the limit so the count can never leave BCD.
    function automatic logic [16:0] bcd_step(input logic [3:0][3:0] d, input logic dir_up);
        logic [3:0][3:0] r;
        logic            c;
        logic [3:0]      lim;
        r = d;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lim = (i == 2) ? 4'd5 : 4'd9;
            if (c) begin
                if (dir_up) begin
                    if (r[i] >= lim) begin
                        r[i] = 4'd0;
                        c    = 1'b1;
                    end else begin
                        r[i] = r[i] + 4'd1;
                        c    = 1'b0;
                    end
                end else begin
                    if (r[i] == 4'd0 || r[i] > lim) begin
                        r[i] = lim;
                        c    = (r[i] == lim) && (d[i] == 4'd0);
                    end else begin
                        r[i] = r[i] - 4'd1;
                        c    = 1'b0;
                    end
                end
            end else begin
                r[i] = r[i];
            end
        end
        return {c, r};
    endfunction

    // Next-state logic: clear wins, otherwise prescaler, count step and lap toggle.
    always_comb begin
        tick_s           = go && (presc_r == TICK_LAST);
        lap_edge_s       = lap && !lap_prev_r;
        step_s           = bcd_step(live_r, up);
        presc_nxt_s      = presc_r;
        live_nxt_s       = live_r;
        lap_val_nxt_s    = lap_val_r;
        lap_active_nxt_s = lap_active_r;
        wrap_nxt_s       = 1'b0;
        if (clr) begin
            presc_nxt_s      = '0;
            live_nxt_s       = '0;
            lap_val_nxt_s    = '0;
            lap_active_nxt_s = 1'b0;
            wrap_nxt_s       = 1'b0;
        end else begin
            if (go) begin
                if (tick_s) begin
                    presc_nxt_s = '0;
                end else begin
                    presc_nxt_s = presc_r + TICK_WIDTH'(1);
                end
            end else begin
                presc_nxt_s = presc_r;
            end
            if (tick_s) begin
                live_nxt_s = step_s[15:0];
                wrap_nxt_s = step_s[16];
            end else begin
                live_nxt_s = live_r;
                wrap_nxt_s = 1'b0;
            end
            // The lap register captures the pre-tick live value.
            if (lap_edge_s) begin
                lap_active_nxt_s = !lap_active_r;
                if (!lap_active_r) begin
                    lap_val_nxt_s = live_r;
                end else begin
                    lap_val_nxt_s = lap_val_r;
                end
            end else begin
                lap_active_nxt_s = lap_active_r;
                lap_val_nxt_s    = lap_val_r;
            end
        end
        if (lap_active_nxt_s) begin
            out_nxt_s = lap_val_nxt_s;
        end else begin
            out_nxt_s = live_nxt_s;
        end
    end

    // State and registered outputs; lap is always sampled so a held-high lap never re-triggers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_r      <= '0;
            live_r       <= '0;
            lap_val_r    <= '0;
            out_r        <= '0;
            wrap_r       <= 1'b0;
            lap_active_r <= 1'b0;
            lap_prev_r   <= 1'b0;
        end else begin
            presc_r      <= presc_nxt_s;
            live_r       <= live_nxt_s;
            lap_val_r    <= lap_val_nxt_s;
            out_r        <= out_nxt_s;
            wrap_r       <= wrap_nxt_s;
            lap_active_r <= lap_active_nxt_s;
            lap_prev_r   <= lap;
        end
    end

    assign parallel_out = out_r;
    assign wrap         = wrap_r;
    assign lap_active   = lap_active_r;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter: directed vector table, corner sequences and
// randomized stimulus against a tenths-of-a-second integer reference model.
module tb_bcd_stopwatch_counter;

    localparam int TF = 4;

    logic            clk;
    logic            clr_n;
    logic            clr;
    logic            go;
    logic            up;
    logic            lap;
    logic [3:0][3:0] parallel_out;
    logic            wrap;
    logic            lap_active;

    int errors;
    int checks;

    int m_pre;
    int m_n;
    int m_lapv;
    bit m_la;
    bit m_prev;
    bit m_wrap;

    typedef struct packed {
        logic        clr;
        logic        go;
        logic        up;
        logic        lap;
        logic [15:0] cycles;
        logic [15:0] exp_n;
        logic        exp_la;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [0:20];

    bcd_stopwatch_counter #(.TICK_WIDTH(8), .TICK_FINAL(TF)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .clr          (clr),
        .go           (go),
        .up           (up),
        .lap          (lap),
        .parallel_out (parallel_out),
        .wrap         (wrap),
        .lap_active   (lap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        logic [3:0] d0, d1, d2, d3;
        d0 = 4'(n % 10);
        d1 = 4'((n / 10) % 10);
        d2 = 4'((n / 100) % 6);
        d3 = 4'(n / 600);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_n    = 0;
        m_lapv = 0;
        m_la   = 1'b0;
        m_prev = 1'b0;
        m_wrap = 1'b0;
    endtask

    // Reference: count kept as total tenths 0..5999, advanced modulo 6000.
    task automatic model_edge();
        bit tick;
        if (clr) begin
            m_pre  = 0;
            m_n    = 0;
            m_lapv = 0;
            m_la   = 1'b0;
            m_wrap = 1'b0;
        end else begin
            tick   = go && (m_pre == TF - 1);
            m_wrap = 1'b0;
            if (lap && !m_prev) begin
                if (!m_la) m_lapv = m_n;
                m_la = !m_la;
            end
            if (go) m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                if (up) begin
                    m_wrap = (m_n == 5999);
                    m_n    = (m_n + 1) % 6000;
                end else begin
                    m_wrap = (m_n == 0);
                    m_n    = (m_n + 5999) % 6000;
                end
            end
        end
        m_prev = lap;
    endtask

    task automatic check_model();
        chk("cycle_digits", 32'(parallel_out), 32'(to_bcd(m_la ? m_lapv : m_n)));
        chk("cycle_wrap", 32'(wrap), 32'(m_wrap));
        chk("cycle_lap_active", 32'(lap_active), 32'(m_la));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr_n  = 1'b0;
        clr    = 1'b0;
        go     = 1'b0;
        up     = 1'b1;
        lap    = 1'b0;
        model_reset();

        //          clr   go    up    lap   cycles  exp_n  la    wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd100, 16'd0,    1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd4,   16'd1,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd40,  16'd11,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd2,   16'd11,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd50,  16'd11,   1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd1,   16'd11,   1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd1,   16'd12,   1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd8,   16'd10,   1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd40,  16'd0,    1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd4,   16'd5999, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd4,   16'd0,    1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd4,   16'd1,    1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd1,   16'd0,    1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd128, 16'd32,   1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1,   16'd32,   1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd79,  16'd32,   1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1,   16'd52,   1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd2,   16'd52,   1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1,   16'd0,    1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd4,   16'd1,    1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd1,   16'd1,    1'b0, 1'b0};

        // Asynchronous reset state, then release between edges.
        #23;
        chk("reset_digits", 32'(parallel_out), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_lap_active", 32'(lap_active), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            clr = vecs[i].clr;
            go  = vecs[i].go;
            up  = vecs[i].up;
            lap = vecs[i].lap;
            run(int'(vecs[i].cycles));
            chk($sformatf("vec%0d_digits", i), 32'(parallel_out), 32'(to_bcd(int'(vecs[i].exp_n))));
            chk($sformatf("vec%0d_lap_active", i), 32'(lap_active), 32'(vecs[i].exp_la));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // 600 ticks up from zero: digits stay BCD and end at 1:00.0.
        clr = 1'b1; go = 1'b1; up = 1'b1; lap = 1'b0;
        step();
        clr = 1'b0;
        for (int c = 0; c < 600 * TF; c++) begin
            step();
            if (parallel_out[2] > 4'd5 || parallel_out[0] > 4'd9 ||
                parallel_out[1] > 4'd9 || parallel_out[3] > 4'd9) begin
                chk("bcd_range", 32'(parallel_out), 32'(to_bcd(m_n)));
            end
        end
        chk("up600_digits", 32'(parallel_out), 32'(to_bcd(600)));

        // Preload 9:59.9 by counting up, wrap up, then wrap back down.
        clr = 1'b1;
        step();
        clr = 1'b0;
        run(5999 * TF);
        chk("preload_9599", 32'(parallel_out), 32'(to_bcd(5999)));
        chk("preload_nowrap", 32'(wrap), 32'd0);
        run(TF);
        chk("wrap_up_digits", 32'(parallel_out), 32'd0);
        chk("wrap_up_pulse", 32'(wrap), 32'd1);
        run(1);
        chk("wrap_up_one_cycle", 32'(wrap), 32'd0);
        up = 1'b0;
        run(TF - 1);
        chk("wrap_down_digits", 32'(parallel_out), 32'h9599);
        chk("wrap_down_pulse", 32'(wrap), 32'd1);
        run(1);
        chk("wrap_down_one_cycle", 32'(wrap), 32'd0);

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            go  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) lap = ~lap;
            clr = ($urandom_range(0, 299) == 0);
            step();
        end

        // Asynchronous reset mid-count takes effect immediately.
        clr = 1'b0; go = 1'b1; up = 1'b1; lap = 1'b0;
        run(37);
        clr_n = 1'b0;
        #1;
        model_reset();
        chk("async_digits", 32'(parallel_out), 32'd0);
        chk("async_lap_active", 32'(lap_active), 32'd0);
        chk("async_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run(2 * TF);
        chk("after_async_digits", 32'(parallel_out), 32'(to_bcd(2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_counter.md
# bcd_stopwatch_counter

Four-digit BCD stopwatch counter: the stage that feeds the seven-segment display multiplexer. It runs a prescaler to generate 0.1 s ticks and counts minutes, tens of seconds, seconds and tenths (format M:SS.T), up or down. It exposes the digits as a 4×4-bit parallel array, with a lap-hold feature that freezes the displayed value while counting continues. The display driver consumes `parallel_out` directly, with digit 0 on the rightmost display.

## Interface
Parameters:
- TICK_WIDTH, 24, width of the prescaler counter.
- TICK_FINAL, 10_000_000, clock cycles per 0.1 s tick (100 MHz clock). Must fit in TICK_WIDTH bits and be ≥ 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of count, prescaler and lap hold.
- go  input  1  level; 1 = run, 0 = pause. Prescaler and digits hold while 0.
- up  input  1  level; 1 = count up, 0 = count down. Sampled at each tick.
- lap  input  1  synchronous level; each rising edge toggles lap-hold mode.
- parallel_out  output  [3:0][3:0] (4 digits × 4 bits)  BCD digits: [0] tenths 0–9, [1] seconds units 0–9, [2] seconds tens 0–5, [3] minutes 0–9.
- wrap  output  1  one-cycle pulse when the count wraps (up past 9:59.9, or down past 0:00.0).
- lap_active  output  1  1 while lap-hold mode is active.

## Operation
- Reset (clr_n = 0, async): prescaler = 0, all digits = 0, lap register = 0, lap_active = 0, wrap = 0, lap edge-detect register = 0. parallel_out reads 0:00.0.
- Prescaler:
  - When go = 1, increments each cycle.
  - When it equals TICK_FINAL−1, the internal tick is asserted for that cycle and the prescaler returns to 0.
  - When go = 0, the prescaler holds its value, so pause/resume does not lose partial time.
- Count up on tick:
  - d0 increments. On 9, d0 → 0 and carries to d1.
  - d1 increments. On 9, d1 → 0 and carries to d2.
  - d2 increments. On 5, d2 → 0 and carries to d3.
  - d3 increments. On 9, d3 → 0 and wrap is pulsed.
  - 9:59.9 → 0:00.0.
- Count down on tick: mirror of count up with borrows. d0 borrows at 0 → 9; d1 at 0 → 9; d2 at 0 → 5; d3 at 0 → 9 with wrap. 0:00.0 → 9:59.9.
- Digits never hold non-BCD values. d2 never exceeds 5.
- Lap:
  - Rising edge of lap (lap = 1, previous sample 0) toggles lap_active.
  - On entry, the current live count is copied into the lap register.
  - parallel_out = lap register while lap_active = 1, else the live count.
  - The live count continues to advance during lap hold.
- clr = 1: on the next edge, prescaler = 0, digits = 0, lap_active = 0, wrap = 0. clr has priority over tick, go and lap in the same cycle. go and up do not affect clr.
- Changing up mid-interval does not reset the prescaler. The new direction applies at the next tick.

## Timing
- Digit update: registered. Digits change on the clock edge that ends the tick cycle, so parallel_out shows the new value one cycle after the prescaler hits TICK_FINAL−1.
- Tick period: exactly TICK_FINAL cycles of go = 1.
- wrap: asserted in the same cycle the wrapped digits (0:00.0 or 9:59.9) first appear. It lasts exactly one cycle.
- lap_active and parallel_out selection: update one cycle after the sampled rising edge of lap.
- Simultaneous lap edge and tick: the lap register captures the pre-tick live value. The live count still advances.
- Simultaneous clr and any other event: the clr result only.
- Asynchronous reset mid-count: all state returns to reset values immediately. Counting resumes from 0:00.0 after release if go = 1.

## Test plan
- Reset/idle:
  - Stimulus: clr_n low, then high; go = 0 for 100 cycles.
  - Required: parallel_out = {0,0,0,0}; wrap = 0; lap_active = 0.
- Up count with rollover (TICK_FINAL = 4, go = 1, up = 1):
  - Stimulus: run 600 ticks.
  - Required: digit sequence 0:00.0 → 0:00.1 … 0:00.9 → 0:01.0 … 0:59.9 → 1:00.0. The d0 update occurs every 4 cycles. d2 never reads 6.
- Full wrap up and down:
  - Stimulus: preload to 9:59.9 by counting up, then one more tick.
  - Required: 0:00.0 with wrap high for one cycle.
  - Stimulus: up = 0, one tick from 0:00.0.
  - Required: 9:59.9 with a wrap pulse.
- Pause:
  - Stimulus: go = 1 for 2 cycles after a tick, then go = 0 for 50 cycles, then go = 1.
  - Required: digits frozen during the pause. The next tick arrives 2 cycles after resume.
- Lap:
  - Stimulus: at 0:03.2, pulse lap; run 20 ticks.
  - Required: parallel_out stays 0:03.2 with lap_active = 1.
  - Stimulus: pulse lap again.
  - Required: parallel_out shows the live value 0:05.2.
- Clear priority:
  - Stimulus: assert clr in the same cycle as a tick and a lap edge.
  - Required: next cycle parallel_out = 0:00.0, lap_active = 0, wrap = 0, and the prescaler restarts from 0.
